alu_op_sequencer: RTL and testbench

- Synthesizable initiator for the registered 4-op ALU (add/sub/and/or, signed NB_DATA-bit operands, 2-bit selector).
- Accepts operand pairs through a valid/ready handshake and drives each pair to the ALU once per op code, sel 00 to 11.
- Captures each ALU result, compares it with an internally computed expected value, and streams out every result with a mismatch flag and a saturating error count.
- Sits between a stimulus source (UART/host or counter) and the ALU top, giving on-chip self-checking.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_ref_model.sv | 24 ++
 rtl/alu_op_sequencer.sv | 110 +++++++++++
 tb/tb_alu_op_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU self-check path: op codes, selector width
// and the sequencer state encoding.
package alu_pkg;

    localparam int NB_SEL = 2;

    localparam logic [NB_SEL-1:0] OP_ADD = 2'b00;
    localparam logic [NB_SEL-1:0] OP_SUB = 2'b01;
    localparam logic [NB_SEL-1:0] OP_AND = 2'b10;
    localparam logic [NB_SEL-1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CHECK = 2'd3
    } state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the 4-op ALU; results wrap modulo 2^NB_DATA.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int NB_DATA = 16
) (
    input  logic [NB_DATA-1:0] dataA,
    input  logic [NB_DATA-1:0] dataB,
    input  logic [NB_SEL-1:0]  sel,
    output logic [NB_DATA-1:0] expected
);

    always_comb begin
        expected = '0;
        case (sel)
            OP_ADD: expected = dataA + dataB;
            OP_SUB: expected = dataA - dataB;
            OP_AND: expected = dataA & dataB;
            OP_OR:  expected = dataA | dataB;
            default: expected = '0;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Drives each accepted operand pair through all four ALU ops, captures the
// results and flags any that disagree with the reference model.
//
// state | meaning
// IDLE  | ready for a new operand pair
// ISSUE | operands and selector stable at the ALU, arm the latency timer
// WAIT  | timer counts down; result captured when it reads 1
// CHECK | result pulse out, advance selector or finish the pair
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int NB_DATA     = 16,
    parameter int ALU_LATENCY = 1,
    parameter int NB_ERR      = 8
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_DATA-1:0] i_opA,
    input  logic [NB_DATA-1:0] i_opB,
    output logic [NB_DATA-1:0] o_dataA,
    output logic [NB_DATA-1:0] o_dataB,
    output logic [NB_SEL-1:0]  o_sel,
    input  logic [NB_DATA-1:0] i_dataC,
    output logic               o_res_valid,
    output logic [NB_DATA-1:0] o_res_data,
    output logic [NB_SEL-1:0]  o_res_sel,
    output logic               o_mismatch,
    output logic [NB_ERR-1:0]  o_err_count,
    output logic               o_busy
);

    localparam int NB_CNT = (ALU_LATENCY < 2) ? 1 : $clog2(ALU_LATENCY + 1);
    localparam logic [NB_CNT-1:0] CNT_LOAD = NB_CNT'(ALU_LATENCY);
    localparam logic [NB_CNT-1:0] CNT_ONE  = NB_CNT'(1);

    state_t             state;
    logic [NB_CNT-1:0]  waitCnt;
    logic [NB_DATA-1:0] expected;
    logic               isMismatch;

    alu_ref_model #(.NB_DATA(NB_DATA)) uRefModel (
        .dataA    (o_dataA),
        .dataB    (o_dataB),
        .sel      (o_sel),
        .expected (expected)
    );

    // Compared at the capture edge so the flag lands together with o_res_data.
    assign isMismatch = (i_dataC != expected);

    assign o_ready = (state == IDLE);
    assign o_busy  = (state != IDLE);

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state       <= IDLE;
            waitCnt     <= '0;
            o_dataA     <= '0;
            o_dataB     <= '0;
            o_sel       <= '0;
            o_res_valid <= 1'b0;
            o_res_data  <= '0;
            o_res_sel   <= '0;
            o_mismatch  <= 1'b0;
            o_err_count <= '0;
        end else begin
            o_res_valid <= 1'b0;
            o_mismatch  <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        o_dataA <= i_opA;
                        o_dataB <= i_opB;
                        o_sel   <= OP_ADD;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    waitCnt <= CNT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    waitCnt <= waitCnt - 1'b1;
                    if (waitCnt == CNT_ONE) begin
                        o_res_data  <= i_dataC;
                        o_res_sel   <= o_sel;
                        o_res_valid <= 1'b1;
                        o_mismatch  <= isMismatch;
                        if (isMismatch && (o_err_count != {NB_ERR{1'b1}})) begin
                            o_err_count <= o_err_count + 1'b1;
                        end
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (o_sel == OP_OR) begin
                        state <= IDLE;
                    end else begin
                        o_sel <= o_sel + 1'b1;
                        state <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: latency-1 ALU model with an optional OR fault, plus a
// latency-2 always-wrong ALU on a 2-bit error counter for saturation.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        orFault;
        logic [15:0] res [4];
        logic [3:0]  mis;
    } vec_t;

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] data;
        logic        mis;
        logic [7:0]  err;
    } pulse_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, valid1, valid2, orFault;
    logic [15:0] opA, opB;

    logic        ready1, resValid1, mis1, busy1;
    logic [15:0] dataA1, dataB1, dataC1, resData1;
    logic [1:0]  sel1, resSel1;
    logic [7:0]  err1;

    logic        ready2, resValid2, mis2, busy2;
    logic [15:0] dataA2, dataB2, dataC2, resData2, stage2;
    logic [1:0]  sel2, resSel2;
    logic [1:0]  err2;

    int checks = 0;
    int failures = 0;
    int strayMis = 0;
    int strayBusy = 0;
    int expErr;
    pulse_t q1 [$];
    pulse_t q2 [$];
    vec_t vecs [5];

    alu_op_sequencer #(.NB_DATA(16), .ALU_LATENCY(1), .NB_ERR(8)) dut1 (
        .clock(clock), .i_reset(reset), .i_valid(valid1), .o_ready(ready1),
        .i_opA(opA), .i_opB(opB), .o_dataA(dataA1), .o_dataB(dataB1), .o_sel(sel1),
        .i_dataC(dataC1), .o_res_valid(resValid1), .o_res_data(resData1),
        .o_res_sel(resSel1), .o_mismatch(mis1), .o_err_count(err1), .o_busy(busy1)
    );

    alu_op_sequencer #(.NB_DATA(16), .ALU_LATENCY(2), .NB_ERR(2)) dut2 (
        .clock(clock), .i_reset(reset), .i_valid(valid2), .o_ready(ready2),
        .i_opA(opA), .i_opB(opB), .o_dataA(dataA2), .o_dataB(dataB2), .o_sel(sel2),
        .i_dataC(dataC2), .o_res_valid(resValid2), .o_res_data(resData2),
        .o_res_sel(resSel2), .o_mismatch(mis2), .o_err_count(err2), .o_busy(busy2)
    );

    function automatic logic [15:0] aluFn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [1:0] s);
        case (s)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    always @(posedge clock)
        dataC1 <= (orFault && sel1 == 2'b11) ? 16'h0000 : aluFn(dataA1, dataB1, sel1);

    always @(posedge clock) begin
        stage2 <= aluFn(dataA2, dataB2, sel2);
        dataC2 <= ~stage2;
    end

    always @(negedge clock) begin
        if (resValid1) q1.push_back('{resSel1, resData1, mis1, err1});
        if (resValid2) q2.push_back('{resSel2, resData2, mis2, {6'b0, err2}});
        if (mis1 && !resValid1) strayMis++;
        if (busy1 == ready1) strayBusy++;
    end

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic waitReady1(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(posedge clock);
            lat++;
            #1;
            if (ready1) break;
        end
    endtask

    task automatic runVec(input vec_t v);
        int lat;
        q1.delete();
        orFault = v.orFault;
        @(negedge clock);
        opA = v.a;
        opB = v.b;
        valid1 = 1'b1;
        checkEq("ready_before_accept", 32'(ready1), 32'd1);
        @(posedge clock);
        #1 valid1 = 1'b0;
        waitReady1(lat);
        checkEq("pair_latency", lat, 12);
        checkEq("pulse_count", q1.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q1.size()) begin
                if (v.mis[i]) expErr = (expErr < 255) ? expErr + 1 : 255;
                checkEq($sformatf("res_sel[%0d]", i), 32'(q1[i].sel), i);
                checkEq($sformatf("res_data[%0d]", i), 32'(q1[i].data), 32'(v.res[i]));
                checkEq($sformatf("mismatch[%0d]", i), 32'(q1[i].mis), 32'(v.mis[i]));
                checkEq($sformatf("err_count[%0d]", i), 32'(q1[i].err), expErr);
            end
        end
        orFault = 1'b0;
    endtask

    task automatic checkReset1(input string tag);
        checkEq({tag, "_ready"}, 32'(ready1), 32'd1);
        checkEq({tag, "_busy"}, 32'(busy1), 32'd0);
        checkEq({tag, "_res_valid"}, 32'(resValid1), 32'd0);
        checkEq({tag, "_dataA"}, 32'(dataA1), 32'd0);
        checkEq({tag, "_dataB"}, 32'(dataB1), 32'd0);
        checkEq({tag, "_sel"}, 32'(sel1), 32'd0);
        checkEq({tag, "_res_data"}, 32'(resData1), 32'd0);
        checkEq({tag, "_res_sel"}, 32'(resSel1), 32'd0);
        checkEq({tag, "_mismatch"}, 32'(mis1), 32'd0);
        checkEq({tag, "_err_count"}, 32'(err1), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, blocked;
        logic held;
        int satErr [8];
        satErr = '{1, 2, 3, 3, 3, 3, 3, 3};

        vecs[0] = '{16'hFFF1, 16'hFFF1, 1'b0, '{16'hFFE2, 16'h0000, 16'hFFF1, 16'hFFF1}, 4'b0000};
        vecs[1] = '{16'h5F0A, 16'h5CC2, 1'b0, '{16'hBBCC, 16'h0248, 16'h5C02, 16'h5FCA}, 4'b0000};
        vecs[2] = '{16'h5F0A, 16'h5CC2, 1'b1, '{16'hBBCC, 16'h0248, 16'h5C02, 16'h0000}, 4'b1000};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 16'h7FFE, 16'h0001, 16'h7FFF}, 4'b0000};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, '{16'h8001, 16'h7FFF, 16'h0000, 16'h8001}, 4'b0000};

        reset = 1'b1; valid1 = 1'b0; valid2 = 1'b0; orFault = 1'b0;
        opA = '0; opB = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkReset1("reset");
        checkEq("reset_err2", 32'(err2), 32'd0);
        reset = 1'b0;

        expErr = 0;
        for (int v = 0; v < 5; v++) runVec(vecs[v]);

        // Backpressure: second pair held on the inputs while the first runs.
        q1.delete();
        @(negedge clock);
        opA = 16'h1234; opB = 16'h0F0F; valid1 = 1'b1;
        @(posedge clock);
        #1 opA = 16'hA5A5; opB = 16'h5A5A;
        blocked = 0;
        held = 1'b1;
        while (blocked < 200) begin
            @(negedge clock);
            if (ready1) break;
            blocked++;
            if (dataA1 !== 16'h1234) held = 1'b0;
        end
        checkEq("bp_blocked_cycles", blocked, 12);
        checkEq("bp_operands_held", 32'(held), 32'd1);
        @(posedge clock);
        #1 valid1 = 1'b0;
        checkEq("bp_second_dataA", 32'(dataA1), 32'hA5A5);
        waitReady1(lat);
        repeat (5) @(negedge clock);
        checkEq("bp_pulses", q1.size(), 8);
        if (q1.size() == 8) begin
            checkEq("bp_first_or", 32'(q1[3].data), 32'h1F3F);
            checkEq("bp_second_add", 32'(q1[4].data), 32'hFFFF);
            checkEq("bp_second_sub", 32'(q1[5].data), 32'h4B4B);
            checkEq("bp_second_sel", 32'(q1[7].sel), 32'd3);
        end

        // Saturation on the 2-bit counter with an always-wrong latency-2 ALU.
        q2.delete();
        for (int p = 0; p < 2; p++) begin
            @(negedge clock);
            opA = 16'h1111; opB = 16'h2222; valid2 = 1'b1;
            @(posedge clock);
            #1 valid2 = 1'b0;
            lat = 0;
            while (lat < 200) begin
                @(posedge clock);
                lat++;
                #1;
                if (ready2) break;
            end
            checkEq("lat2_pair", lat, 16);
        end
        checkEq("sat_pulses", q2.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < q2.size()) begin
                checkEq($sformatf("sat_err[%0d]", i), 32'(q2[i].err), satErr[i]);
                checkEq($sformatf("sat_mis[%0d]", i), 32'(q2[i].mis), 32'd1);
                checkEq($sformatf("sat_sel[%0d]", i), 32'(q2[i].sel), i % 4);
            end
        end

        // Reset one cycle after the sel=1 ISSUE aborts the pair.
        q1.delete();
        @(negedge clock);
        opA = 16'h0003; opB = 16'h0001; valid1 = 1'b1;
        @(posedge clock);
        #1 valid1 = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkEq("rst_pre_sel", 32'(sel1), 32'd1);
        checkEq("rst_pre_busy", 32'(busy1), 32'd1);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
        checkReset1("midreset");
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        checkEq("rst_pulses", q1.size(), 1);
        if (q1.size() == 1) checkEq("rst_first_add", 32'(q1[0].data), 32'h0004);
        expErr = 0;
        runVec(vecs[1]);

        checkEq("stray_mismatch", strayMis, 0);
        checkEq("busy_ready_decode", strayBusy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
